// File: rtl/xintf_dpbram_bridge_if.sv
// xintf_dpbram_bridge_if: the two DPBRAM ports driven by the XINTF bridge.
// z_to_d_*: DPBRAM read port (XINTF reads from the RAM).
// d_to_z_*: DPBRAM write port (XINTF writes into the RAM).
interface xintf_dpbram_bridge_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] z_to_d_addr;
    logic              z_to_d_ce;
    logic              z_to_d_we;
    logic [DATA_W-1:0] z_to_d_dout;
    logic [ADDR_W-1:0] d_to_z_addr;
    logic              d_to_z_ce;
    logic              d_to_z_we;
    logic [DATA_W-1:0] d_to_z_din;

    modport master (
        output z_to_d_addr, z_to_d_ce, z_to_d_we,
        input  z_to_d_dout,
        output d_to_z_addr, d_to_z_ce, d_to_z_we, d_to_z_din
    );

    modport slave (
        input  z_to_d_addr, z_to_d_ce, z_to_d_we,
        output z_to_d_dout,
        input  d_to_z_addr, d_to_z_ce, d_to_z_we, d_to_z_din
    );
endinterface

// File: rtl/xintf_dpbram_bridge.sv
// xintf_dpbram_bridge: bridges an asynchronous XINTF strobe bus onto a
// dual-port BRAM. Reads drive the XD bus from a registered copy of the RAM
// read port; writes are committed once CS&WE have been low for WR_DLY cycles,
// exactly once per strobe. i_wf_en locks the XINTF side out completely.
// Optional feature: define XINTF_SYNC_EN to pass CS/WE through 2-flop
// synchronizers (reset to 1) before they reach the FSM.
module xintf_dpbram_bridge #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int WR_DLY = 3,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wf_en,
    input  logic              i_nZ_B_CS,
    input  logic              i_nZ_B_WE,
    input  logic [ADDR_W-1:0] i_Z_B_XA,
    inout  wire  [DATA_W-1:0] io_Z_B_XD,
    output logic [CNT_W-1:0]  o_wr_cnt,
    output logic              o_short_wr,
    xintf_dpbram_bridge_if.master dp
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD      = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_WR_HOLD = 2'd3;

    localparam logic [3:0] WR_DLY_C = 4'(WR_DLY);

    logic cs_s;
    logic we_s;

`ifdef XINTF_SYNC_EN
    logic [1:0] cs_sync_q;
    logic [1:0] we_sync_q;

    // Two-stage synchronizers for the asynchronous strobes, idle-high on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_sync_q <= 2'b11;
            we_sync_q <= 2'b11;
        end else begin
            cs_sync_q <= {cs_sync_q[0], i_nZ_B_CS};
            we_sync_q <= {we_sync_q[0], i_nZ_B_WE};
        end
    end

    assign cs_s = cs_sync_q[1];
    assign we_s = we_sync_q[1];
`else
    assign cs_s = i_nZ_B_CS;
    assign we_s = i_nZ_B_WE;
`endif

    logic [1:0]        state_q,    state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] xd_q,       xd_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_din_q,   wr_din_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [CNT_W-1:0]  wr_cnt_q,   wr_cnt_d;
    logic              short_q,    short_d;
    logic              armed_q,    armed_d;
    logic              xd_oe_s;

    // Next-state, write-commit and read-capture logic for the strobe FSM.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        xd_d       = xd_q;
        wr_addr_d  = wr_addr_q;
        wr_din_d   = wr_din_q;
        wr_pulse_d = 1'b0;
        wr_cnt_d   = wr_cnt_q;
        short_d    = 1'b0;
        // After reset an access is only accepted once CS has been seen high,
        // so a strobe already in flight at reset release is ignored.
        armed_d    = armed_q | cs_s;

        if (i_wf_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q && !cs_s) begin
                        if (we_s) begin
                            state_d = S_RD;
                        end else begin
                            state_d    = S_WR_WAIT;
                            wait_cnt_d = 4'd1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RD: begin
                    xd_d = dp.z_to_d_dout;
                    if (cs_s) begin
                        state_d = S_IDLE;
                    end else if (!we_s) begin
                        state_d    = S_WR_WAIT;
                        wait_cnt_d = 4'd1;
                    end else begin
                        state_d = S_RD;
                    end
                end
                S_WR_WAIT: begin
                    if (cs_s || we_s) begin
                        short_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (wait_cnt_q == WR_DLY_C) begin
                        wr_addr_d  = i_Z_B_XA;
                        wr_din_d   = io_Z_B_XD;
                        wr_pulse_d = 1'b1;
                        wr_cnt_d   = wr_cnt_q + CNT_W'(1);
                        state_d    = S_WR_HOLD;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    if (cs_s || we_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR_HOLD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset abandons any access in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            xd_q       <= '0;
            wr_addr_q  <= '0;
            wr_din_q   <= '0;
            wr_pulse_q <= 1'b0;
            wr_cnt_q   <= '0;
            short_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            xd_q       <= xd_d;
            wr_addr_q  <= wr_addr_d;
            wr_din_q   <= wr_din_d;
            wr_pulse_q <= wr_pulse_d;
            wr_cnt_q   <= wr_cnt_d;
            short_q    <= short_d;
            armed_q    <= armed_d;
        end
    end

    // XD is driven only while reading; a falling WE releases it in the same cycle.
    assign xd_oe_s   = (state_q == S_RD) && we_s;
    assign io_Z_B_XD = xd_oe_s ? xd_q : {DATA_W{1'bz}};

    assign dp.z_to_d_ce   = (state_q == S_RD);
    assign dp.z_to_d_addr = (state_q == S_RD) ? i_Z_B_XA : {ADDR_W{1'b0}};
    assign dp.z_to_d_we   = 1'b0;

    assign dp.d_to_z_addr = wr_addr_q;
    assign dp.d_to_z_din  = wr_din_q;
    assign dp.d_to_z_ce   = wr_pulse_q;
    assign dp.d_to_z_we   = wr_pulse_q;

    assign o_wr_cnt   = wr_cnt_q;
    assign o_short_wr = short_q;

endmodule
